// File: rtl/cache_arb_pkg.sv
// Shared types for the two-port cache arbiter: FSM states, requesting port and
// cache operation.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache between an instruction read port and a
// data read/write port; one transaction in flight, latched at grant.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_miss,
  output logic [DATA_W-1:0] i_rd_data,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_miss,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              c_rd_req,
  output logic              c_wr_req,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wr_data,
  input  logic              c_miss,
  input  logic [DATA_W-1:0] c_rd_data
);

  arb_state_t        r_state;
  arb_port_t         r_last_grant;
  arb_port_t         r_port;
  arb_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_i_rd_data;
  logic [DATA_W-1:0] r_d_rd_data;

  logic w_i_act;
  logic w_d_act;
  logic w_grant_i;
  logic w_grant_d;
  logic w_busy;
  logic w_done_i;
  logic w_done_d;

  // On a tie the port that did not win last time gets the cache.
  assign w_i_act   = i_rd_req;
  assign w_d_act   = d_rd_req | d_wr_req;
  assign w_grant_d = w_d_act & (~w_i_act | (r_last_grant == PORT_I));
  assign w_grant_i = w_i_act & ~w_grant_d;

  assign w_busy   = (r_state == BUSY_I) | (r_state == BUSY_D);
  assign w_done_i = (r_state == DONE) & (r_port == PORT_I);
  assign w_done_d = (r_state == DONE) & (r_port == PORT_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_I;
      r_port       <= PORT_I;
      r_op         <= OP_RD;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_i_rd_data  <= '0;
      r_d_rd_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_port       <= PORT_D;
            r_last_grant <= PORT_D;
            r_op         <= d_wr_req ? OP_WR : OP_RD;
            r_addr       <= d_addr;
            r_wr_data    <= d_wr_data;
            r_state      <= BUSY_D;
          end else if (w_grant_i) begin
            r_port       <= PORT_I;
            r_last_grant <= PORT_I;
            r_op         <= OP_RD;
            r_addr       <= i_addr;
            r_wr_data    <= '0;
            r_state      <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (!c_miss) r_state <= DONE;
        end
        DONE: begin
          // The cache presents read data one cycle after completion, i.e. now.
          if (r_op == OP_RD) begin
            if (r_port == PORT_I) r_i_rd_data <= c_rd_data;
            else                  r_d_rd_data <= c_rd_data;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign c_rd_req  = w_busy & (r_op == OP_RD);
  assign c_wr_req  = w_busy & (r_op == OP_WR);
  assign c_addr    = r_addr;
  assign c_wr_data = r_wr_data;

  assign i_miss    = w_i_act & ~w_done_i;
  assign d_miss    = w_d_act & ~w_done_d;
  assign i_rd_data = r_i_rd_data;
  assign d_rd_data = r_d_rd_data;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a behavioural cache with adjustable miss
// latency sits behind the arbiter and every cache transaction is checked in order.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rd_req;
  logic [AW-1:0] i_addr;
  logic          i_miss;
  logic [DW-1:0] i_rd_data;
  logic          d_rd_req;
  logic          d_wr_req;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wr_data;
  logic          d_miss;
  logic [DW-1:0] d_rd_data;
  logic          c_rd_req;
  logic          c_wr_req;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wr_data;
  logic          c_miss;
  logic [DW-1:0] c_rd_data;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_addr(i_addr), .i_miss(i_miss), .i_rd_data(i_rd_data),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_miss(d_miss), .d_rd_data(d_rd_data),
    .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_addr(c_addr), .c_wr_data(c_wr_data),
    .c_miss(c_miss), .c_rd_data(c_rd_data)
  );

  typedef struct {
    bit          port;
    bit          isWr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        sbQ[$];
  txn_t        curExp;
  logic [31:0] cacheMem [0:1023];
  logic [31:0] refMem   [0:1023];
  int          missLat = 0;
  int          cnt = 0;
  int          cycleNum = 0;
  int          assertCount = 0;
  int          failCount = 0;
  int          iDone[$];
  bit          doneNext = 1'b0;
  bit          rdNext = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Behavioural cache: misses for missLat cycles, then completes; read data is registered.
  assign c_miss = (c_rd_req || c_wr_req) && (cnt < missLat);

  always @(posedge clk) begin
    cycleNum <= cycleNum + 1;
    if (rst) begin
      cnt       <= 0;
      c_rd_data <= '0;
    end else if (c_rd_req || c_wr_req) begin
      if (c_miss) cnt <= cnt + 1;
      else begin
        cnt <= 0;
        if (c_wr_req) cacheMem[c_addr[11:2]] <= c_wr_data;
        else          c_rd_data <= cacheMem[c_addr[11:2]];
      end
    end
  end

  // Monitor: pop on cache completion, then check the DONE cycle and the read data after it.
  always @(negedge clk) begin
    if (rst) begin
      doneNext = 1'b0;
      rdNext   = 1'b0;
    end else begin
      if (rdNext) begin
        if (curExp.port) checkOutput("d_rd_data", d_rd_data, curExp.data);
        else             checkOutput("i_rd_data", i_rd_data, curExp.data);
        rdNext = 1'b0;
      end
      if (doneNext) begin
        checkOutput("done_c_req", {c_rd_req, c_wr_req}, 2'b00);
        if (curExp.port) begin
          checkOutput("done_d_miss", d_miss, 1'b0);
          checkOutput("done_i_miss", i_miss, i_rd_req);
        end else begin
          checkOutput("done_i_miss", i_miss, 1'b0);
          checkOutput("done_d_miss", d_miss, d_rd_req | d_wr_req);
        end
        rdNext   = !curExp.isWr;
        doneNext = 1'b0;
      end
      if ((c_rd_req || c_wr_req) && !c_miss) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_txn", {c_rd_req, c_wr_req}, 2'b00);
        end else begin
          curExp = sbQ.pop_front();
          checkOutput("txn_op", {c_rd_req, c_wr_req}, curExp.isWr ? 2'b01 : 2'b10);
          checkOutput("txn_addr", c_addr, curExp.addr);
          if (curExp.isWr) checkOutput("txn_wdata", c_wr_data, curExp.data);
          doneNext = 1'b1;
        end
      end
    end
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    cacheMem[addr[11:2]] = data;
    refMem[addr[11:2]]   = data;
  endtask

  task automatic pushExp(input bit port, input bit isWr, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.port = port;
    t.isWr = isWr;
    t.addr = addr;
    if (isWr) begin
      refMem[addr[11:2]] = data;
      t.data = data;
    end else begin
      t.data = refMem[addr[11:2]];
    end
    sbQ.push_back(t);
  endtask

  task automatic doReset();
    rst      = 1'b1;
    i_rd_req = 1'b0;
    d_rd_req = 1'b0;
    d_wr_req = 1'b0;
    missLat  = 0;
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitMissLow(input bit isD, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (isD ? !d_miss : !i_miss) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("miss_low_in_time", ok, 1'b1);
  endtask

  task automatic waitDrain();
    int k = 0;
    while ((sbQ.size() != 0 || doneNext || rdNext) && k < 400) begin
      @(negedge clk);
      k++;
    end
    checkOutput("scoreboard_drained", sbQ.size() == 0, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Holds i_rd_req across n completions, stepping the address by one word each time.
  task automatic iPort(input logic [31:0] base, input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      i_addr   = base + 32'(4 * k);
      i_rd_req = 1'b1;
      waitMissLow(1'b0, ok);
      iDone.push_back(cycleNum);
      @(posedge clk);
      #1;
    end
    i_rd_req = 1'b0;
  endtask

  // mode 0 = read, 1 = write, 2 = read and write together.
  task automatic dPort(input int mode, input logic [31:0] base, input logic [31:0] dataBase, input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      d_addr    = base + 32'(4 * k);
      d_wr_data = dataBase + 32'(k);
      d_rd_req  = (mode != 1);
      d_wr_req  = (mode != 0);
      waitMissLow(1'b1, ok);
      @(posedge clk);
      #1;
    end
    d_rd_req = 1'b0;
    d_wr_req = 1'b0;
  endtask

  task automatic applyStimulus();
    bit ok;
    bit seen;
    bit addrOk;
    bit iMissOk;
    int busy;

    // Single instruction hit: exact cycle-by-cycle timing.
    doReset();
    pushExp(1'b0, 1'b0, 32'h100, 32'h0);
    i_addr   = 32'h100;
    i_rd_req = 1'b1;
    @(negedge clk);
    checkOutput("hit_c1_c_rd_req", c_rd_req, 1'b0);
    checkOutput("hit_c1_i_miss", i_miss, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("hit_c2_c_rd_req", c_rd_req, 1'b1);
    checkOutput("hit_c2_i_miss", i_miss, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("hit_c3_i_miss", i_miss, 1'b0);
    checkOutput("hit_c3_c_rd_req", c_rd_req, 1'b0);
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    @(negedge clk);
    checkOutput("hit_c4_i_rd_data", i_rd_data, 32'hCAFE0001);
    waitDrain();

    // Back-to-back hits from one port issue every 3 cycles.
    doReset();
    iDone.delete();
    for (int k = 0; k < 3; k++) pushExp(1'b0, 1'b0, 32'h100 + 32'(4 * k), 32'h0);
    iPort(32'h100, 3);
    checkOutput("b2b_interval_0", iDone[1] - iDone[0], 3);
    checkOutput("b2b_interval_1", iDone[2] - iDone[1], 3);
    waitDrain();

    // Simultaneous requests after reset: D first, then I; then read back the write.
    doReset();
    pushExp(1'b1, 1'b1, 32'h300, 32'h12345678);
    pushExp(1'b0, 1'b0, 32'h200, 32'h0);
    fork
      dPort(1, 32'h300, 32'h12345678, 1);
      iPort(32'h200, 1);
    join
    pushExp(1'b1, 1'b0, 32'h300, 32'h0);
    dPort(0, 32'h300, 32'h0, 1);
    waitDrain();
    checkOutput("d_readback_0x300", d_rd_data, 32'h12345678);

    // Continuous requests on both ports alternate D, I, D, I ...
    doReset();
    for (int k = 0; k < 5; k++) begin
      pushExp(1'b1, 1'b1, 32'h400 + 32'(4 * k), 32'h50000000 + 32'(k));
      pushExp(1'b0, 1'b0, 32'h500 + 32'(4 * k), 32'h0);
    end
    fork
      dPort(1, 32'h400, 32'h50000000, 5);
      iPort(32'h500, 5);
    join
    waitDrain();

    // Long D read miss while I waits.
    doReset();
    missLat = 19;
    pushExp(1'b1, 1'b0, 32'h600, 32'h0);
    pushExp(1'b0, 1'b0, 32'h100, 32'h0);
    d_addr   = 32'h600;
    d_rd_req = 1'b1;
    i_addr   = 32'h100;
    i_rd_req = 1'b1;
    busy = 0; addrOk = 1'b1; iMissOk = 1'b1; ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (c_rd_req) begin
        busy++;
        if (c_addr !== 32'h600) addrOk = 1'b0;
      end
      if (!i_miss) iMissOk = 1'b0;
      if (!d_miss) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    d_rd_req = 1'b0;
    missLat  = 0;
    checkOutput("miss_d_done", ok, 1'b1);
    checkOutput("miss_busy_cycles", busy, 20);
    checkOutput("miss_c_addr_stable", addrOk, 1'b1);
    checkOutput("miss_i_held", iMissOk, 1'b1);
    waitMissLow(1'b0, ok);
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    waitDrain();

    // D write whose requester leaves mid-transaction still lands at the latched address.
    doReset();
    missLat = 5;
    pushExp(1'b1, 1'b1, 32'h700, 32'hDEADBEEF);
    d_addr    = 32'h700;
    d_wr_data = 32'hDEADBEEF;
    d_wr_req  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (c_wr_req) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("wr_grant_seen", seen, 1'b1);
    @(posedge clk); #1;
    d_wr_req  = 1'b0;
    d_addr    = 32'h7F0;
    d_wr_data = 32'h0BADF00D;
    waitDrain();
    missLat = 0;
    checkOutput("mem_0x700", cacheMem[32'h700 >> 2], 32'hDEADBEEF);
    checkOutput("mem_0x7F0", cacheMem[32'h7F0 >> 2], 32'h0);
    pushExp(1'b1, 1'b0, 32'h700, 32'h0);
    dPort(0, 32'h700, 32'h0, 1);
    waitDrain();

    // Read and write together resolve to a write; d_rd_data keeps its value.
    pushExp(1'b1, 1'b1, 32'h800, 32'h11112222);
    dPort(2, 32'h800, 32'h11112222, 1);
    waitDrain();
    checkOutput("rdwr_d_rd_data_kept", d_rd_data, 32'hDEADBEEF);
    checkOutput("mem_0x800", cacheMem[32'h800 >> 2], 32'h11112222);

    // Reset in the middle of BUSY_I.
    doReset();
    pushExp(1'b0, 1'b0, 32'h100, 32'h0);
    iPort(32'h100, 1);
    waitDrain();
    checkOutput("pre_rst_i_rd_data", i_rd_data, 32'hCAFE0001);
    missLat  = 10;
    i_addr   = 32'h104;
    i_rd_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (c_rd_req) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("busy_i_seen", seen, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    sbQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_c_rd_req", c_rd_req, 1'b0);
    checkOutput("rst_i_rd_data", i_rd_data, 32'h0);
    checkOutput("rst_i_miss", i_miss, 1'b1);
    missLat = 0;
    pushExp(1'b0, 1'b0, 32'h104, 32'h0);
    waitMissLow(1'b0, ok);
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    waitDrain();
  endtask

  initial begin
    rst       = 1'b1;
    i_rd_req  = 1'b0;
    i_addr    = '0;
    d_rd_req  = 1'b0;
    d_wr_req  = 1'b0;
    d_addr    = '0;
    d_wr_data = '0;
    for (int k = 0; k < 1024; k++) begin
      cacheMem[k] = '0;
      refMem[k]   = '0;
    end
    preload(32'h100, 32'hCAFE0001);
    preload(32'h104, 32'hC0DE0104);
    preload(32'h108, 32'hC0DE0108);
    preload(32'h200, 32'hA5A50200);
    preload(32'h600, 32'h66660600);
    for (int k = 0; k < 5; k++) preload(32'h500 + 32'(4 * k), 32'h60000000 + 32'(k));

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_c_rd_req", c_rd_req, 1'b0);
    checkOutput("reset_c_wr_req", c_wr_req, 1'b0);
    checkOutput("reset_c_addr", c_addr, 32'h0);
    checkOutput("reset_c_wr_data", c_wr_data, 32'h0);
    checkOutput("reset_i_rd_data", i_rd_data, 32'h0);
    checkOutput("reset_d_rd_data", d_rd_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
